// File: rtl/wb_intercon.sv
// Single-master Wishbone classic interconnect.
// Base/mask address decode, ack steering, miss/timeout error termination.
module wb_intercon #(
  parameter int              NSLV     = 6,
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              SW       = DW / 8,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_cyc_i,
  input  logic               m_stb_i,
  input  logic               m_we_i,
  input  logic [AW-1:0]      m_adr_i,
  input  logic [DW-1:0]      m_dat_i,
  input  logic [SW-1:0]      m_sel_i,
  output logic               m_ack_o,
  output logic               m_err_o,
  output logic [DW-1:0]      m_dat_o,
  output logic [NSLV-1:0]    s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [SW-1:0]      s_sel_o,
  input  logic [NSLV-1:0]    s_ack_i,
  input  logic [NSLV*DW-1:0] s_dat_i,
  output logic [7:0]         err_cnt_o,
  output logic [AW-1:0]      err_adr_o
);

  localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [AW-1:0]     err_adr_q, err_adr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              hit;
  logic [SELW-1:0]   dec_idx;
  logic [NSLV-1:0]   dec_oh;
  logic [NSLV-1:0]   sel_oh;
  logic [NSLV-1:0]   act_oh;
  logic [NSLV-1:0]   ack_v;
  logic              start;
  logic              enter_err;

  assign s_stb_o = m_stb_i;
  assign s_we_o  = m_we_i;
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;

  // Holding the decoder quiet while in reset drops s_cyc_o at once.
  assign start = m_cyc_i & m_stb_i & rst_n;

  // Address decode; scanning downwards lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    dec_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        dec_idx = SELW'(i);
      end
    end
  end

  // One-hot forms of the live decode and of the frozen selection.
  always_comb begin
    dec_oh = '0;
    sel_oh = '0;
    for (int i = 0; i < NSLV; i++) begin
      dec_oh[i] = (dec_idx == SELW'(i));
      sel_oh[i] = (sel_q == SELW'(i));
    end
  end

  // Next-state, slave select and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    act_oh    = '0;
    m_err_o   = 1'b0;
    enter_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (hit) begin
            act_oh = dec_oh;
            if (!(|(s_ack_i & dec_oh))) begin
              state_d = BUSY;
              sel_d   = dec_idx;
              cnt_d   = CW'(1);
              adr_d   = m_adr_i;
            end
          end else begin
            state_d   = ERR;
            enter_err = 1'b1;
            err_adr_d = m_adr_i;
          end
        end
      end
      BUSY: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else begin
          act_oh = sel_oh;
          if (|(s_ack_i & sel_oh)) begin
            state_d = IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_C)) begin
            state_d   = ERR;
            enter_err = 1'b1;
            err_adr_d = adr_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ERR: begin
        m_err_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Only the selected slave may ack; its data is muxed while acking.
  always_comb begin
    ack_v   = s_ack_i & act_oh;
    m_dat_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (ack_v[i]) begin
        m_dat_o = m_dat_o | s_dat_i[i*DW +: DW];
      end
    end
  end

  assign m_ack_o   = |ack_v;
  assign s_cyc_o   = act_oh;
  assign err_cnt_o = err_cnt_q;
  assign err_adr_o = err_adr_q;

  // State, selection, timeout counter and error capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      adr_q     <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_intercon.sv
// Bench for wb_intercon: directed corner cases plus random
// transactions checked against a transaction-level outcome model.
module tb_wb_intercon;

  localparam int NS = 6;
  localparam int TO = 4;

  localparam logic [NS*32-1:0] BASES = {
    32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
    32'h2000_0000, 32'h4000_0000, 32'h8000_0000};

  logic            clk;
  logic            rst_n;
  logic            m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]     m_adr_i, m_dat_i;
  logic [3:0]      m_sel_i;
  logic            m_ack_o, m_err_o;
  logic [31:0]     m_dat_o;
  logic [NS-1:0]   s_cyc_o;
  logic            s_stb_o, s_we_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic [NS-1:0]   s_ack_i;
  logic [NS*32-1:0] s_dat_i;
  logic [7:0]      err_cnt_o;
  logic [31:0]     err_adr_o;

  logic [31:0]     sdat [NS];
  int              total = 0;
  int              bad = 0;
  int              errs = 0;

  wb_intercon #(
    .NSLV(NS), .AW(32), .DW(32),
    .SLV_BASE(BASES), .SLV_MASK(BASES),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .err_cnt_o(err_cnt_o), .err_adr_o(err_adr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_dat_i = '0;
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = sdat[k];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first slave whose masked address equals its base.
  function automatic int ref_dec(input logic [31:0] a);
    logic [31:0] b;
    for (int i = 0; i < NS; i++) begin
      b = BASES[i*32 +: 32];
      if ((a & b) == b) return i;
    end
    return -1;
  endfunction

  // One master transaction; outcome predicted from decode, ack timing
  // and the timeout bound, then compared every cycle.
  task automatic run_txn(input logic [31:0] adr, input int ack_slv,
                         input int delay, input logic [NS-1:0] stray);
    int sel, term;
    bit is_err;
    logic [NS-1:0] oh, strm, a;
    sel = ref_dec(adr);
    oh = (sel >= 0) ? (NS'(1) << sel) : '0;
    strm = stray & ~oh;
    if (sel < 0) begin
      term = 1; is_err = 1;
    end else if (ack_slv == sel && delay >= 0 && delay <= TO) begin
      term = delay; is_err = 0;
    end else begin
      term = TO + 1; is_err = 1;
    end
    for (int c = 0; c <= term; c++) begin
      @(posedge clk); #1;
      m_cyc_i = 1'b1;
      m_stb_i = 1'b1;
      if (c == 0) begin
        m_adr_i = adr;
        m_we_i  = 1'($urandom);
        m_dat_i = $urandom;
        m_sel_i = 4'($urandom);
      end else begin
        m_adr_i = $urandom;
      end
      for (int k = 0; k < NS; k++) sdat[k] = $urandom;
      a = strm;
      if (c == delay && ack_slv >= 0) a = a | (NS'(1) << ack_slv);
      s_ack_i = a;
      #4;
      if (c == 0) chk("bcast_adr", s_adr_o, adr);
      if (is_err && c == term) begin
        errs = (errs < 255) ? errs + 1 : 255;
        chk("err_ack", m_ack_o, 0);
        chk("err_err", m_err_o, 1);
        chk("err_cyc", s_cyc_o, 0);
        chk("err_cnt", err_cnt_o, errs);
        chk("err_adr", err_adr_o, adr);
      end else if (c == term) begin
        chk("ack_ack", m_ack_o, 1);
        chk("ack_err", m_err_o, 0);
        chk("ack_cyc", s_cyc_o, oh);
        chk("ack_dat", m_dat_o, sdat[sel]);
      end else begin
        chk("wait_ack", m_ack_o, 0);
        chk("wait_err", m_err_o, 0);
        chk("wait_cyc", s_cyc_o, oh);
        chk("wait_dat", m_dat_o, 0);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    s_ack_i = 6'($urandom);
    #4;
    chk("idle_ack", m_ack_o, 0);
    chk("idle_err", m_err_o, 0);
    chk("idle_cyc", s_cyc_o, 0);
  endtask

  initial begin
    logic [31:0] adr;
    int sel, aslv, dly;
    rst_n = 1'b0;
    m_cyc_i = 0; m_stb_i = 0; m_we_i = 0;
    m_adr_i = 0; m_dat_i = 0; m_sel_i = 0;
    s_ack_i = 0;
    for (int k = 0; k < NS; k++) sdat[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_adr", err_adr_o, 0);
    rst_n = 1'b1;

    run_txn(32'h4000_0010, 1, 3, '0);
    idle_cycle();
    run_txn(32'h0000_0004, 0, -1, '0);
    idle_cycle();
    run_txn(32'h8000_0000, 0, -1, '0);
    run_txn(32'h8000_0000, 0, 3, 6'b000100);
    run_txn(32'h2000_0000, 2, TO, '0);
    run_txn(32'h0400_0008, 5, 0, 6'h3F);
    run_txn(32'hC000_0000, 1, 1, '0);
    idle_cycle();

    // Master abort while BUSY, even with the selected slave acking.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h1000_0040; s_ack_i = 0;
    #4 chk("ab_cyc0", s_cyc_o, 6'b001000);
    @(posedge clk); #1;
    m_adr_i = $urandom;
    #4 chk("ab_cyc1", s_cyc_o, 6'b001000);
    @(posedge clk); #1;
    m_cyc_i = 0; m_stb_i = 0; s_ack_i = 6'b001000;
    #4;
    chk("ab_cyc2", s_cyc_o, 0);
    chk("ab_ack2", m_ack_o, 0);
    chk("ab_err2", m_err_o, 0);
    idle_cycle();

    // Reset pulse while BUSY with the master still holding the cycle.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0800_0000; s_ack_i = 0;
    #4 chk("rb_cyc0", s_cyc_o, 6'b010000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    errs = 0;
    #1;
    chk("rb_cyc", s_cyc_o, 0);
    chk("rb_ack", m_ack_o, 0);
    chk("rb_err", m_err_o, 0);
    chk("rb_cnt", err_cnt_o, 0);
    chk("rb_adr", err_adr_o, 0);
    m_cyc_i = 0; m_stb_i = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    for (int n = 0; n < 60; n++) begin
      adr = $urandom;
      if ($urandom_range(0, 3) == 0) adr = adr & 32'h03FF_FFFF;
      sel = ref_dec(adr);
      if (sel >= 0 && $urandom_range(0, 3) != 0) aslv = sel;
      else aslv = $urandom_range(0, NS - 1);
      dly = $urandom_range(0, TO + 2) - 1;
      run_txn(adr, aslv, dly, 6'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    for (int n = 0; n < 300; n++) begin
      adr = $urandom & 32'h03FF_FFFF;
      run_txn(adr, 0, -1, 6'($urandom));
    end
    idle_cycle();
    chk("sat_cnt", err_cnt_o, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_intercon.md
# wb_intercon

Parametrised single-master Wishbone (classic) interconnect that replaces the fixed one-hot address-bit decode in the top level. It decodes the master address against NSLV base/mask pairs, routes cycles to exactly one slave, and accepts ack and data only from the selected slave. Unmapped accesses and slaves that stall beyond a bound terminate with a one-cycle `m_err_o`, so the core can never hang. Error events are counted and the last faulting address is captured for firmware.

## Interface
- `NSLV`, 6: number of slave ports (1..16).
- `AW`, 32: address width.
- `DW`, 32: data width; `SW = DW/8` select bits.
- `SLV_BASE`, {NSLV{AW'h0}}: packed bases; slave i = bits [i*AW +: AW].
- `SLV_MASK`, {NSLV{AW'h0}}: packed masks; slave i hit when `(m_adr_i & mask_i) == base_i`.
- `TIMEOUT`, 255: max BUSY cycles without slave ack; 0 disables the timeout.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i` in 1 each: master cycle, strobe, write enable.
- `m_adr_i` in AW; `m_dat_i` in DW; `m_sel_i` in SW: master address, write data, byte select.
- `m_ack_o` out 1: ack from the selected slave.
- `m_err_o` out 1: error termination.
- `m_dat_o` out DW: read data.
- `s_cyc_o` out NSLV: one-hot slave cycle.
- `s_stb_o`, `s_we_o` out 1; `s_adr_o` out AW; `s_dat_o` out DW; `s_sel_o` out SW: broadcast copies of the master signals.
- `s_ack_i` in NSLV; `s_dat_i` in NSLV*DW: slave acks and packed read data.
- `err_cnt_o` out 8: saturating error count.
- `err_adr_o` out AW: address of the most recent error.

## Operation
- Decode is combinational. With overlapping hits, the lowest index wins. `hit` = any slave matched.
- FSM states: IDLE, BUSY, ERR. Register `sel_q` holds the selected slave; `cnt` is the timeout counter of width clog2(TIMEOUT+1).
- IDLE, when `m_cyc_i & m_stb_i`:
  - If `hit`: `s_cyc_o` = decoded one-hot in the same cycle.
    - Decoded slave acks in the same cycle: `m_ack_o`=1, stay in IDLE.
    - Otherwise: go to BUSY, `sel_q`<=decoded slave, `cnt`<=1.
  - If no hit: `s_cyc_o`=0; go to ERR.
- BUSY:
  - `s_cyc_o[sel_q]` = `m_cyc_i`; the decode is frozen, so address changes are ignored.
  - `m_cyc_i`=0: abort. Go to IDLE with no ack and no err.
  - `s_ack_i[sel_q]`=1: `m_ack_o`=1 in the same cycle. Go to IDLE.
  - Else if TIMEOUT!=0 and `cnt`==TIMEOUT: go to ERR.
  - Else `cnt`++.
- ERR: `m_err_o`=1 for exactly one cycle, `s_cyc_o`=0. Go to IDLE.
- Acks from slaves that are not selected are ignored in every state.
- `m_dat_o` = `s_dat_i` of the acking selected slave while `m_ack_o`=1; 0 otherwise. `m_ack_o` and `m_err_o` are never high together.
- On each entry to ERR, from either decode miss or timeout:
  - `err_cnt_o` increments, saturating at 255.
  - `err_adr_o` <= `m_adr_i` sampled at decode time. For timeouts, use an internal latched copy of the address.
- `s_stb_o` and the other broadcast signals are pure wires from the master.

## Timing
- Reset (asynchronous): state=IDLE, `sel_q`=0, `cnt`=0, `err_cnt_o`=0, `err_adr_o`=0. Consequently `m_ack_o`=0, `m_err_o`=0, `m_dat_o`=0, `s_cyc_o`=0.
- Reset asserted mid-transaction drops `s_cyc_o` immediately, with no ack or err.
- Added latency on a hit is zero: a slave ack in cycle N gives `m_ack_o` in cycle N.
- Decode miss: `m_err_o` asserted in cycle N+1 after a strobe in cycle N.
- Timeout: the strobe enters BUSY at cycle N. `m_err_o` is asserted at cycle N+TIMEOUT+1.
- Back-to-back: a new strobe arriving on the cycle after ack or err is decoded afresh in IDLE.
- Slave ack in the same cycle that `cnt` reaches TIMEOUT: the ack wins and no error is raised.

## Test plan
- Defaults with bases 0x8000_0000 / 0x4000_0000 and mask = base. Read 0x4000_0010; slave 1 acks on cycle 3 with 0xDEADBEEF -> `s_cyc_o`=6'b000010, `m_ack_o` on cycle 3, `m_dat_o`=0xDEADBEEF.
- Access 0x0000_0004, which matches no slave -> `m_err_o` for one cycle on the next clock, `err_cnt_o`=1, `err_adr_o`=0x0000_0004, `s_cyc_o` stays 0.
- TIMEOUT=4, selected slave never acks -> `m_err_o` 5 cycles after the strobe, `s_cyc_o` drops in the err cycle, `err_cnt_o` increments.
- Selected slave 0 is BUSY while slave 2 pulses `s_ack_i[2]` -> no `m_ack_o`. A later `s_ack_i[0]` gives `m_ack_o`.
- Master drops `m_cyc_i` in BUSY, and separately `rst_n` is pulsed low in BUSY -> IDLE, `s_cyc_o`=0, no ack/err. After reset, all outputs are 0.
- Force 300 decode errors -> `err_cnt_o` saturates at 255. A same-cycle ack at `cnt`==TIMEOUT -> ack, no err.
